// File: rtl/input_deglitch_pkg.sv
// Purpose : shared types and constants for the input_deglitch block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, glitch counter ceiling, qualify counter width.
package input_deglitch_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        QUAL_HIGH = 2'd1,
        HIGH      = 2'd2,
        QUAL_LOW  = 2'd3
    } dg_state_t;

    localparam logic [15:0] GLITCH_CNT_MAX = 16'hFFFF;
    localparam int          QCNT_W         = 8;

endpackage

// File: rtl/input_deglitch_sync2.sv
// Purpose : two-flop synchroniser for an asynchronous pin.
// Latency : 2 clk from input change to o_q.
// Backpressure: none; samples every cycle.
//
// Ports:
//   i_clk   - sampling clock
//   i_rst_n - asynchronous active-low reset, clears both stages
//   i_d     - unsynchronised input
//   o_q     - synchronised output (second stage)
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/input_deglitch.sv
// Purpose : synchronise and deglitch a field input, emit clean level, edge strobes and stall flag.
// Latency : FILTER_CYCLES+2 clk from first high sample of raw_in to sig_out/rise_pulse (same for falls).
// Backpressure: none; free-running, outputs valid every cycle.
//
// Ports:
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   raw_in       - unsynchronised pin
//   sig_out      - filtered level
//   rise_pulse   - one-cycle strobe on accepted 0->1
//   fall_pulse   - one-cycle strobe on accepted 1->0
//   stalled      - high once TIMEOUT_CYCLES elapse with no accepted edge
//   glitch_count - saturating count of rejected pulses
// Build option: define INPUT_DEGLITCH_GLITCH_CNT_EN to build the glitch counter;
// otherwise glitch_count is tied to zero.
module input_deglitch
    import input_deglitch_pkg::*;
#(
    parameter int          FILTER_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        raw_in,
    output logic        sig_out,
    output logic        rise_pulse,
    output logic        fall_pulse,
    output logic        stalled,
    output logic [15:0] glitch_count
);

    localparam logic [QCNT_W-1:0] FILT = QCNT_W'(FILTER_CYCLES);
    localparam logic [31:0]       TMO  = TIMEOUT_CYCLES;

    logic              w_s2;
    dg_state_t         r_state;
    dg_state_t         w_state_nxt;
    logic [QCNT_W-1:0] r_qcnt;
    logic [QCNT_W-1:0] w_qcnt_nxt;
    logic [QCNT_W-1:0] w_qcnt_inc;
    logic              w_rise;
    logic              w_fall;
    logic              w_glitch;
    logic              w_edge;
    logic [31:0]       r_tcnt;
    logic [31:0]       w_tcnt_nxt;
    logic              r_sig;
    logic              r_rise;
    logic              r_fall;
    logic              r_stalled;

    sync2 u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (raw_in),
        .o_q     (w_s2)
    );

    // qcnt never exceeds FILTER_CYCLES-1 (<=254), so the 8-bit increment cannot wrap.
    assign w_qcnt_inc = r_qcnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOW;
            r_qcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_qcnt  <= w_qcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_glitch    = 1'b0;
        case (r_state)
            LOW: begin
                if (w_s2) begin
                    // With a filter of one the first differing sample is already enough.
                    if (FILTER_CYCLES == 1) begin
                        w_state_nxt = HIGH;
                        w_rise      = 1'b1;
                    end else begin
                        w_state_nxt = QUAL_HIGH;
                        w_qcnt_nxt  = QCNT_W'(1);
                    end
                end
            end
            QUAL_HIGH: begin
                if (w_s2) begin
                    if (w_qcnt_inc == FILT) begin
                        w_state_nxt = HIGH;
                        w_qcnt_nxt  = '0;
                        w_rise      = 1'b1;
                    end else begin
                        w_qcnt_nxt  = w_qcnt_inc;
                    end
                end else begin
                    w_state_nxt = LOW;
                    w_qcnt_nxt  = '0;
                    w_glitch    = 1'b1;
                end
            end
            HIGH: begin
                if (!w_s2) begin
                    if (FILTER_CYCLES == 1) begin
                        w_state_nxt = LOW;
                        w_fall      = 1'b1;
                    end else begin
                        w_state_nxt = QUAL_LOW;
                        w_qcnt_nxt  = QCNT_W'(1);
                    end
                end
            end
            QUAL_LOW: begin
                if (!w_s2) begin
                    if (w_qcnt_inc == FILT) begin
                        w_state_nxt = LOW;
                        w_qcnt_nxt  = '0;
                        w_fall      = 1'b1;
                    end else begin
                        w_qcnt_nxt  = w_qcnt_inc;
                    end
                end else begin
                    w_state_nxt = HIGH;
                    w_qcnt_nxt  = '0;
                    w_glitch    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = LOW;
                w_qcnt_nxt  = '0;
            end
        endcase
    end

    // Timeout: stalled is registered from the next count so it drops in the
    // same cycle the edge strobe rises.
    assign w_edge     = w_rise | w_fall;
    assign w_tcnt_nxt = w_edge          ? 32'd0  :
                        (r_tcnt == TMO) ? r_tcnt : r_tcnt + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig     <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_tcnt    <= 32'd0;
            r_stalled <= 1'b0;
        end else begin
            r_rise    <= w_rise;
            r_fall    <= w_fall;
            r_tcnt    <= w_tcnt_nxt;
            r_stalled <= (w_tcnt_nxt == TMO);
            if (w_rise) begin
                r_sig <= 1'b1;
            end else if (w_fall) begin
                r_sig <= 1'b0;
            end
        end
    end

    assign sig_out    = r_sig;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign stalled    = r_stalled;

`ifdef INPUT_DEGLITCH_GLITCH_CNT_EN
    logic [15:0] r_glitch_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_cnt <= 16'h0000;
        end else if (w_glitch && (r_glitch_cnt != GLITCH_CNT_MAX)) begin
            r_glitch_cnt <= r_glitch_cnt + 16'd1;
        end
    end

    assign glitch_count = r_glitch_cnt;
`else
    logic w_unused_glitch;
    assign w_unused_glitch = w_glitch;
    assign glitch_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_input_deglitch.sv
// Purpose : randomized scoreboard bench for input_deglitch (filter 8 and filter 1 instances).
// Latency : n/a.
// Backpressure: n/a.
module tb_input_deglitch;

    localparam int FA = 8;
    localparam int FB = 1;
    localparam int TO = 100;
`ifdef INPUT_DEGLITCH_GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic raw_a = 1'b0;
    logic raw_b = 1'b0;

    logic        a_sig, a_rise, a_fall, a_stl;
    logic [15:0] a_gc;
    logic        b_sig, b_rise, b_fall, b_stl;
    logic [15:0] b_gc;

    always #5 clk = ~clk;

    input_deglitch #(.FILTER_CYCLES(FA), .TIMEOUT_CYCLES(TO)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_in       (raw_a),
        .sig_out      (a_sig),
        .rise_pulse   (a_rise),
        .fall_pulse   (a_fall),
        .stalled      (a_stl),
        .glitch_count (a_gc)
    );

    input_deglitch #(.FILTER_CYCLES(FB), .TIMEOUT_CYCLES(TO)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_in       (raw_b),
        .sig_out      (b_sig),
        .rise_pulse   (b_rise),
        .fall_pulse   (b_fall),
        .stalled      (b_stl),
        .glitch_count (b_gc)
    );

    typedef struct packed {
        logic        sig;
        logic        rise;
        logic        fall;
        logic        stl;
        logic [15:0] gc;
    } obs_t;

    obs_t qa[$];
    obs_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a level change is accepted once F consecutive synchronised
    // samples agree on the new value; a run of the opposite value that ends
    // before that is a glitch. Stall = F-independent cycles since last accepted edge.
    bit m_d1[2], m_d2[2], m_prev[2], m_lvl[2];
    int m_streak[2], m_cnt[2], m_gl[2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_d1[i] = 0; m_d2[i] = 0; m_prev[i] = 0; m_lvl[i] = 0;
            m_streak[i] = 0; m_cnt[i] = 0; m_gl[i] = 0;
        end
    endfunction

    function automatic obs_t model_step(int i, bit raw, int f);
        bit   s;
        bit   acc;
        obs_t o;
        s = m_d2[i];
        m_d2[i] = m_d1[i];
        m_d1[i] = raw;
        if (s != m_prev[i] && m_prev[i] != m_lvl[i] && m_gl[i] < 65535) m_gl[i]++;
        m_streak[i] = (s == m_prev[i]) ? m_streak[i] + 1 : 1;
        m_prev[i] = s;
        acc = (m_streak[i] >= f) && (s != m_lvl[i]);
        if (acc) m_lvl[i] = s;
        if (acc) m_cnt[i] = 0;
        else if (m_cnt[i] < TO) m_cnt[i]++;
        o.sig  = m_lvl[i];
        o.rise = acc && s;
        o.fall = acc && !s;
        o.stl  = (m_cnt[i] == TO);
        o.gc   = GC_EN ? 16'(m_gl[i]) : 16'h0000;
        return o;
    endfunction

    task automatic cmp(input string nm, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got sig=%b rise=%b fall=%b stalled=%b glitch=%0d, want sig=%b rise=%b fall=%b stalled=%b glitch=%0d",
                     nm, $time, act.sig, act.rise, act.fall, act.stl, act.gc,
                     exp.sig, exp.rise, exp.fall, exp.stl, exp.gc);
        end
    endtask

    // Monitor: every DUT output cycle is matched against the oldest predicted one.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                cmp("dut_a", {a_sig, a_rise, a_fall, a_stl, a_gc}, e);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                cmp("dut_b", {b_sig, b_rise, b_fall, b_stl, b_gc}, e);
            end
        end
    end

    task automatic cyc(input bit a, input bit b);
        @(posedge clk);
        if (rst_n) begin
            qa.push_back(model_step(0, raw_a, FA));
            qb.push_back(model_step(1, raw_b, FB));
        end
        #1;
        raw_a = a;
        raw_b = b;
    endtask

    int t = 0;
    task automatic run(input bit a, input int n);
        for (int k = 0; k < n; k++) begin
            cyc(a, ((t / 5) % 2) == 1);
            t++;
        end
    endtask

    task automatic chk_zero(input string nm);
        obs_t z;
        z = '0;
        cmp(nm, {a_sig, a_rise, a_fall, a_stl, a_gc}, z);
        cmp(nm, {b_sig, b_rise, b_fall, b_stl, b_gc}, z);
    endtask

    initial begin
        bit va, vb;
        int ra, rb;
        model_reset();
        #1 rst_n = 1'b0;
        #2 chk_zero("reset_values");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run(0, 5);
        run(1, 20);                      // accepted rise on A
        run(0, 20);                      // accepted fall on A
        repeat (3) begin                 // three 7-sample glitches on A
            run(1, 7);
            run(0, 6);
        end
        run(0, 130);                     // A stalls after its last fall
        run(1, 20);                      // rise clears A stall
        repeat (120) cyc(1, 1);          // B held high -> B stalls
        repeat (5) cyc(1, 0);            // B fall clears its stall
        repeat (20) cyc(0, 0);

        // Abort a rise qualification on A at qcnt=4 with async reset.
        cyc(1, 0);
        repeat (5) cyc(1, 0);
        @(posedge clk);
        #1;
        qa.delete();
        qb.delete();
        rst_n = 1'b0;
        #1 chk_zero("mid_qual_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (20) cyc(1, 0);           // must requalify from scratch

        // Random run lengths: A straddles the filter length, B short runs.
        va = 1'b1; vb = 1'b0; ra = 0; rb = 0;
        for (int k = 0; k < 1500; k++) begin
            if (ra == 0) begin va = ~va; ra = $urandom_range(1, 12); end
            if (rb == 0) begin vb = ~vb; rb = $urandom_range(1, 3); end
            cyc(va, vb);
            ra--;
            rb--;
        end
        repeat (3) cyc(va, vb);
        @(negedge clk);
        #1;
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_deglitch.md
# input_deglitch

Conditions a raw, asynchronous field input (encoder, spindle index, tach pulse) before it reaches the frequency/period counter. Synchronises the pin, rejects pulses shorter than a programmable number of clock cycles, and drives a clean level plus single-cycle rise/fall strobes. Also flags a stalled input when no accepted edge occurs within a timeout, so the counter's stale period word can be ignored downstream.

## Interface
- FILTER_CYCLES, 8: consecutive identical samples required to accept a level change; legal range 1..255.
- TIMEOUT_CYCLES, 1000000: cycles without an accepted edge before `stalled` asserts; legal range 1..2^32-1.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- raw_in  input  1  unsynchronised pin.
- sig_out  output  1  filtered level; drives the counter's SIGNAL input.
- rise_pulse  output  1  one-cycle strobe on accepted 0→1.
- fall_pulse  output  1  one-cycle strobe on accepted 1→0.
- stalled  output  1  high while the timeout has elapsed since the last accepted edge.
- glitch_count  output  16  saturating count of rejected pulses.

## Operation
- Two-flop synchroniser: s1 <= raw_in, s2 <= s1; the FSM uses only s2.
- FSM states: LOW, QUAL_HIGH, HIGH, QUAL_LOW. 8-bit qualify counter `qcnt`.
- LOW: s2=1 → QUAL_HIGH with qcnt=1. If FILTER_CYCLES=1, go directly to HIGH instead.
- QUAL_HIGH, s2=1: if qcnt+1 == FILTER_CYCLES → HIGH; otherwise qcnt++.
- QUAL_HIGH, s2=0 → LOW; counts one glitch.
- HIGH, QUAL_LOW: mirror image of the above.
- Entering HIGH: sig_out=1 and rise_pulse=1 for exactly one cycle. Entering LOW from QUAL_LOW: sig_out=0 and fall_pulse=1. Returning from a QUAL state to its origin produces no pulse.
- sig_out, rise_pulse and fall_pulse are registered. rise_pulse and fall_pulse are never high together.
- Timeout counter `tcnt` (32-bit):
  - Cleared to 0 on any accepted edge.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - stalled = (tcnt == TIMEOUT_CYCLES), registered.
  - On an accepted edge, stalled falls in the same cycle the pulse rises.
- glitch_count increments by 1 per rejected qualification and saturates at 0xFFFF; it is never cleared except by reset.

## Timing
- Reset values: sig_out=0, rise_pulse=0, fall_pulse=0, stalled=0, glitch_count=0, state LOW, s1=s2=0, qcnt=0, tcnt=0.
- Reset is asynchronous; assertion mid-qualification aborts immediately with no pulse and no glitch count.
- Latency: raw_in first sampled high at edge 1 gives sig_out/rise_pulse high after edge FILTER_CYCLES+2, for a steady input. Falling edges are symmetric.
- Minimum accepted pulse width: FILTER_CYCLES cycles. Shorter pulses are rejected and counted.
- A pulse of exactly FILTER_CYCLES-1 samples is rejected.
- stalled asserts TIMEOUT_CYCLES cycles after the last accepted edge (or after reset if no edge ever arrives).
- Input stuck high from reset: one rise is accepted, then stalled asserts TIMEOUT_CYCLES cycles later.

## Configuration
- INPUT_DEGLITCH_GLITCH_CNT_EN defined: the glitch counter is built and glitch_count behaves as above.
- Macro undefined: no counter logic is built; glitch_count is tied to 16'h0000. FSM, pulses and stall behaviour are identical in both builds.

## Structure
- Shared package holds:
  - FSM state typedef: LOW=2'd0, QUAL_HIGH=2'd1, HIGH=2'd2, QUAL_LOW=2'd3.
  - GLITCH_CNT_MAX = 16'hFFFF.
  - Qualify-counter width constant (8).
- One natural sub-module: `sync2`, the two-flop synchroniser with async active-low reset, reusable for other Remora pins.

## Test plan
- FILTER_CYCLES=8: raw_in high for 20 cycles → one rise_pulse, sig_out high after edge 10 from the first sample; glitch_count=0.
- FILTER_CYCLES=8: 7-cycle high pulse, repeated 3 times → no rise_pulse, sig_out stays 0, glitch_count=3.
- FILTER_CYCLES=1: square wave with period 10 cycles → rise/fall pulses alternate every 5 cycles, latency 3 cycles.
- TIMEOUT_CYCLES=100: one accepted rise, then constant input → stalled high exactly 100 cycles after rise_pulse. Next accepted fall → stalled low in the fall_pulse cycle.
- rst_n asserted at qcnt=4 of a rise qualification → all outputs 0 immediately. After release, the FSM requires a full new qualification before accepting.
- Build without INPUT_DEGLITCH_GLITCH_CNT_EN, 5 glitches applied → glitch_count stays 0 and pulse outputs match the enabled build cycle-for-cycle.
